// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: forwarding-mux selects for EX operands and load-use stall for ID
// Tracks destination tags of instructions past EX in an internal shift pipe, so the
// datapath only supplies EX/ID fields.
// Ports:
//   clk, rst_n    clock (rising edge) and synchronous active-low reset
//   ex_valid      EX holds a real instruction (0 = bubble)
//   ex_reg_write  EX instruction writes rd
//   ex_is_load    EX instruction is a load
//   ex_rd         EX destination register
//   ex_src        EX source registers, operand i at [i*REG_AW +: REG_AW]
//   id_src        ID source registers, same packing
//   id_src_used   ID operand i reads a register
//   flush         kill the ID and EX instructions this cycle
//   forward_sel   per EX operand: 0 = regfile, k = tag entry k
//   stall         hold PC/ID; datapath inserts an EX bubble
//   hazard_err    sticky: an EX operand consumed a load result before it was forwardable
//   fwd_count     saturating count of cycles with any forwarding
//   stall_count   saturating count of stall cycles
module fwd_hazard_unit #(
    parameter int REG_AW    = 5,
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int LOAD_LAT  = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1),
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic                      ex_reg_write,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  forward_sel,
    output logic                      stall,
    output logic                      hazard_err,
    output logic [CNT_W-1:0]          fwd_count,
    output logic [CNT_W-1:0]          stall_count
);
    logic [FWD_DEPTH:1]  tag_v;
    logic [FWD_DEPTH:1]  tag_ld;
    logic [REG_AW-1:0]   tag_rd [1:FWD_DEPTH];
    logic [NUM_SRC-1:0]  sel_ld_early;
    logic [NUM_SRC-1:0]  id_hit_early;
    logic                fwd_any;
    logic                err_any;

    // Scan oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        forward_sel  = '0;
        sel_ld_early = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (ex_valid && tag_v[k] && tag_rd[k] == ex_src[i*REG_AW +: REG_AW]) begin
                    forward_sel[i*SEL_W +: SEL_W] = SEL_W'(k);
                    sel_ld_early[i] = tag_ld[k] && (k < LOAD_LAT);
                end
            end
        end
    end

    // ID producer search: entry k sits at position k+1, EX (position 1) is youngest.
    always_comb begin
        id_hit_early = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (tag_v[k] && tag_rd[k] == id_src[i*REG_AW +: REG_AW])
                    id_hit_early[i] = tag_ld[k] && (k + 1 < LOAD_LAT);
            end
            if (ex_valid && ex_reg_write && ex_rd == id_src[i*REG_AW +: REG_AW])
                id_hit_early[i] = ex_is_load && (LOAD_LAT > 1);
            if (!id_src_used[i] || id_src[i*REG_AW +: REG_AW] == '0)
                id_hit_early[i] = 1'b0;
        end
    end

    assign stall   = |id_hit_early && !flush;
    assign fwd_any = |forward_sel;
    assign err_any = |sel_ld_early;

    // r0 writers and flushed instructions enter invalid, so they can never match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_v       <= '0;
            hazard_err  <= 1'b0;
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            tag_v[1] <= ex_valid && ex_reg_write && ex_rd != '0 && !flush;
            for (int k = 2; k <= FWD_DEPTH; k++)
                tag_v[k] <= tag_v[k-1];
            hazard_err <= hazard_err || err_any;
            if (fwd_any && !(&fwd_count))
                fwd_count <= fwd_count + 1'b1;
            if (stall && !(&stall_count))
                stall_count <= stall_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        tag_rd[1] <= ex_rd;
        tag_ld[1] <= ex_is_load;
        for (int k = 2; k <= FWD_DEPTH; k++) begin
            tag_rd[k] <= tag_rd[k-1];
            tag_ld[k] <= tag_ld[k-1];
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: scoreboard bench for fwd_hazard_unit (defaults, CNT_W=4)
module tb_fwd_hazard_unit;
    localparam int D    = 2;
    localparam int LL   = 2;
    localparam int CMAX = 15;

    typedef struct {
        int s0;
        int s1;
        int st;
        int err;
        int fc;
        int sc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ex_valid;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic [9:0] ex_src;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic       flush;
    logic [3:0] forward_sel;
    logic       stall;
    logic       hazard_err;
    logic [3:0] fwd_count;
    logic [3:0] stall_count;

    fwd_hazard_unit #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_src(ex_src), .id_src(id_src),
        .id_src_used(id_src_used), .flush(flush), .forward_sel(forward_sel),
        .stall(stall), .hazard_err(hazard_err), .fwd_count(fwd_count),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    int m_v[1:D], m_rd[1:D], m_ld[1:D], n_v[1:D], n_rd[1:D], n_ld[1:D];
    int m_err, m_fc, m_sc, n_err, n_fc, n_sc;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", tag, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic wr, input logic ld, input int rd,
                       input int s0, input int s1, input int i0, input int i1,
                       input logic [1:0] u, input logic fl);
        ex_valid     = v;
        ex_reg_write = wr;
        ex_is_load   = ld;
        ex_rd        = 5'(rd);
        ex_src       = {5'(s1), 5'(s0)};
        id_src       = {5'(i1), 5'(i0)};
        id_src_used  = u;
        flush        = fl;
    endtask

    // Reference model: expectation for the current cycle plus next state.
    task automatic model_push();
        exp_t e;
        int sel[2];
        int st, er, fa, s, t, pos, ld;
        st = 0; er = 0; fa = 0;
        for (int i = 0; i < 2; i++) begin
            s = int'(ex_src[i*5 +: 5]);
            sel[i] = 0;
            if (ex_valid)
                for (int k = 1; k <= D; k++)
                    if (sel[i] == 0 && m_v[k] != 0 && m_rd[k] == s) sel[i] = k;
            if (sel[i] != 0) begin
                fa = 1;
                if (m_ld[sel[i]] != 0 && sel[i] < LL) er = 1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            t = int'(id_src[i*5 +: 5]);
            pos = 0; ld = 0;
            if (id_src_used[i] && t != 0) begin
                if (ex_valid && ex_reg_write && int'(ex_rd) == t) begin
                    pos = 1; ld = int'(ex_is_load);
                end
                for (int k = 1; k <= D; k++)
                    if (pos == 0 && m_v[k] != 0 && m_rd[k] == t) begin
                        pos = k + 1; ld = m_ld[k];
                    end
                if (pos != 0 && ld != 0 && pos < LL) st = 1;
            end
        end
        if (flush) st = 0;
        e.s0 = sel[0]; e.s1 = sel[1]; e.st = st;
        e.err = m_err; e.fc = m_fc; e.sc = m_sc;
        q.push_back(e);
        n_rd = m_rd; n_ld = m_ld;
        if (!rst_n) begin
            for (int k = 1; k <= D; k++) n_v[k] = 0;
            n_err = 0; n_fc = 0; n_sc = 0;
        end else begin
            for (int k = D; k >= 2; k--) begin
                n_v[k] = m_v[k-1]; n_rd[k] = m_rd[k-1]; n_ld[k] = m_ld[k-1];
            end
            n_v[1]  = int'(ex_valid && ex_reg_write && ex_rd != 0 && !flush);
            n_rd[1] = int'(ex_rd);
            n_ld[1] = int'(ex_is_load);
            n_err = (m_err != 0 || er != 0) ? 1 : 0;
            n_fc  = (fa != 0 && m_fc < CMAX) ? m_fc + 1 : m_fc;
            n_sc  = (st != 0 && m_sc < CMAX) ? m_sc + 1 : m_sc;
        end
    endtask

    task automatic cyc();
        exp_t e;
        model_push();
        @(negedge clk);
        e = q.pop_front();
        chk("sel0", int'(forward_sel[1:0]), e.s0);
        chk("sel1", int'(forward_sel[3:2]), e.s1);
        chk("stall", int'(stall), e.st);
        chk("hazard_err", int'(hazard_err), e.err);
        chk("fwd_count", int'(fwd_count), e.fc);
        chk("stall_count", int'(stall_count), e.sc);
        @(posedge clk);
        m_v = n_v; m_rd = n_rd; m_ld = n_ld;
        m_err = n_err; m_fc = n_fc; m_sc = n_sc;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        for (int k = 1; k <= D; k++) begin
            m_v[k] = 0; m_rd[k] = 0; m_ld[k] = 0;
        end
        m_err = 0; m_fc = 0; m_sc = 0;
        @(posedge clk);
        #1;
        // T1 reset with live, matching inputs
        drv(1, 1, 0, 5, 5, 5, 5, 5, 2'b11, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1 chk("t1_sel", int'(forward_sel), 0);
        cyc();
        chk("t1_fcnt", int'(fwd_count), 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        cyc();
        // T2 ALU chain
        drv(1, 1, 0, 5, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 0, 0, 0, 5, 0, 0, 0, 2'b00, 0);
        #1 chk("t2_c1_sel0", int'(forward_sel[1:0]), 1);
        cyc();
        drv(1, 0, 0, 0, 0, 5, 0, 0, 2'b00, 0);
        #1 chk("t2_c2_sel1", int'(forward_sel[3:2]), 2);
        cyc();
        drv(1, 0, 0, 0, 5, 0, 0, 0, 2'b00, 0);
        #1 chk("t2_c3_sel0", int'(forward_sel[1:0]), 0);
        cyc();
        chk("t2_fcnt", int'(fwd_count), 2);
        // T3 youngest producer wins
        drv(1, 1, 0, 7, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        cyc();
        drv(1, 0, 0, 0, 7, 0, 0, 0, 2'b00, 0);
        #1 chk("t3_sel0", int'(forward_sel[1:0]), 1);
        cyc();
        // T4 load-use
        drv(1, 1, 1, 3, 0, 0, 3, 0, 2'b01, 0);
        #1 chk("t4_c0_stall", int'(stall), 1);
        cyc();
        chk("t4_scnt", int'(stall_count), 1);
        drv(0, 0, 0, 0, 0, 0, 3, 0, 2'b01, 0);
        #1 chk("t4_c1_stall", int'(stall), 0);
        cyc();
        drv(1, 0, 0, 0, 3, 0, 0, 0, 2'b00, 0);
        #1 chk("t4_c2_sel0", int'(forward_sel[1:0]), 2);
        cyc();
        chk("t4_herr", int'(hazard_err), 0);
        // T5 r0 and flush
        drv(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 1, 0, 11, 0, 0, 0, 0, 2'b00, 0);
        #1 chk("t5_r0_sel0", int'(forward_sel[1:0]), 0);
        cyc();
        drv(1, 1, 1, 9, 0, 0, 9, 0, 2'b01, 1);
        #1 chk("t5_flush_stall", int'(stall), 0);
        cyc();
        drv(1, 0, 0, 0, 9, 11, 0, 0, 2'b00, 0);
        #1 chk("t5_flushed_sel0", int'(forward_sel[1:0]), 0);
        chk("t5_older_sel1", int'(forward_sel[3:2]), 2);
        cyc();
        // T6 hazard error and saturation
        drv(1, 1, 1, 4, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        drv(1, 0, 0, 0, 4, 0, 0, 0, 2'b00, 0);
        #1 chk("t6_sel0", int'(forward_sel[1:0]), 1);
        cyc();
        chk("t6_herr_set", int'(hazard_err), 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        repeat (10) cyc();
        chk("t6_herr_held", int'(hazard_err), 1);
        drv(1, 1, 1, 6, 0, 0, 6, 0, 2'b01, 0);
        repeat (20) cyc();
        chk("t6_scnt_sat", int'(stall_count), 15);
        // Random traffic with occasional mid-run reset
        repeat (400) begin
            rst_n = ($urandom_range(0, 59) != 0);
            drv(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 9) == 0));
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
